dma_channel_arbiter: RTL

// Request arbiter for the 4-channel DMA controller. Resolves DREQ/software requests under fixed or rotating priority.

---
 rtl/dma_channel_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/dma_channel_arbiter.sv
// Request arbiter for the 4-channel DMA controller: picks a winning channel,
// runs the HRQ/HLDA bus handshake and owns the mask and software-request registers.
module dma_channel_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic              dreqSenseLow,
  input  logic              dackSenseHigh,
  input  logic              rotatePri,
  input  logic              maskWr,
  input  logic [NUM_CH-1:0] maskData,
  input  logic              softReqWr,
  input  logic [CH_W-1:0]   softReqCh,
  input  logic              HLDA,
  input  logic              xferDone,
  input  logic              tc,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic              grantValid,
  output logic [CH_W-1:0]   grantCh,
  output logic [NUM_CH-1:0] maskQ,
  output logic [1:0]        dbgState
);

  // Handshake: HRQ is a level request held from REQ through SERVE; the CPU
  // answers with HLDA held high for as long as the bus is lent. Dropping HLDA
  // while serving aborts the transfer; xferDone is a one-cycle completion pulse.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVE   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t            state, stateNext;
  logic [NUM_CH-1:0] softReq, softNext, maskNext;
  logic [NUM_CH-1:0] effReq;
  logic [CH_W-1:0]   priPtr, ptrNext, winner;
  logic              winFound, latchGrant, commit;
  logic [NUM_CH-1:0] dackOneHot;

  // Software requests bypass the mask on purpose.
  assign effReq = ((DREQ ^ {NUM_CH{dreqSenseLow}}) & ~maskQ) | softReq;

  // Search from the rotation pointer (or from channel 0) wrapping at NUM_CH.
  always_comb begin
    winner   = '0;
    winFound = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      int idx;
      idx = ((rotatePri ? int'(priPtr) : 0) + k) % NUM_CH;
      if (!winFound && effReq[idx]) begin
        winner   = CH_W'(idx);
        winFound = 1'b1;
      end
    end
  end

  always_comb begin
    stateNext  = state;
    latchGrant = 1'b0;
    commit     = 1'b0;
    case (state)
      S_IDLE: begin
        if (winFound) begin
          stateNext  = S_REQ;
          latchGrant = 1'b1;
        end
      end
      S_REQ: begin
        // Winner is frozen here; only its own request going away backs out.
        if (!effReq[grantCh])  stateNext = S_IDLE;
        else if (HLDA)         stateNext = S_SERVE;
      end
      S_SERVE: begin
        if (!HLDA) begin
          stateNext = S_RELEASE;
        end else if (xferDone) begin
          stateNext = S_RELEASE;
          commit    = 1'b1;
        end
      end
      S_RELEASE: stateNext = S_IDLE;
      default:   stateNext = S_IDLE;
    endcase
  end

  // A host mask write lands first so a terminal count in the same cycle still sticks.
  always_comb begin
    maskNext = maskWr ? maskData : maskQ;
    softNext = softReq;
    if (softReqWr) softNext[softReqCh] = 1'b1;
    if (commit) begin
      softNext[grantCh] = 1'b0;
      if (tc) maskNext[grantCh] = 1'b1;
    end
    ptrNext = (grantCh == CH_W'(NUM_CH - 1)) ? '0 : grantCh + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state   <= S_IDLE;
      grantCh <= '0;
      maskQ   <= '1;
      softReq <= '0;
      priPtr  <= '0;
    end else begin
      state   <= stateNext;
      maskQ   <= maskNext;
      softReq <= softNext;
      if (latchGrant)          grantCh <= winner;
      if (commit && rotatePri) priPtr  <= ptrNext;
    end
  end

  assign HRQ        = (state == S_REQ) || (state == S_SERVE);
  assign grantValid = (state == S_SERVE);
  assign dackOneHot = grantValid ? (NUM_CH'(1) << grantCh) : '0;
  assign DACK       = dackSenseHigh ? dackOneHot : ~dackOneHot;
  assign dbgState   = state;

endmodule
